uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVERSAMPLE, 16, sample ticks per bit period.
REQ-002 Parameter: DATA_BITS, 8, data bits per frame; 8N1 framing, LSB first.
REQ-003 Port: sysclk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: sample_tick  input  1  one-sysclk enable pulse from the baud generator at OVERSAMPLE x baud (16 x 9600 = 153600 Hz).
REQ-006 Port: rxd  input  1  asynchronous serial line; idle high.
REQ-007 Port: rx_data  output  DATA_BITS  last correctly framed byte; holds value until the next valid frame.
REQ-008 Port: rx_valid  output  1  one-sysclk pulse; rx_data is updated on this cycle.
REQ-009 Port: frame_err  output  1  one-sysclk pulse when the stop bit samples low.
REQ-010 Port: rx_busy  output  1  high in any state other than IDLE.

Function
REQ-011 rxd shall pass through a 2-flop synchronizer, preset to 1 on reset; logic uses only the synchronized value rxs.
REQ-012 All counters and the FSM shall advance only on cycles with sample_tick=1; they hold otherwise.
REQ-013 States: IDLE, START, DATA, STOP; 4-bit tick counter tcnt; 3-bit bit counter bcnt.
REQ-014 IDLE: on a tick where the previous-tick rxs=1 and current rxs=0 (falling edge), go to START with tcnt=0.
REQ-015 START: when tcnt reaches OVERSAMPLE/2-1 (7), rxs=1 means a glitch: return to IDLE with no output pulse; rxs=0 means go to DATA with tcnt=0, bcnt=0.
REQ-016 DATA: when tcnt=OVERSAMPLE-1 (15), shift rxs into the MSB of the shift register (shift right), reset tcnt, increment bcnt; after bit DATA_BITS-1, go to STOP.
REQ-017 STOP: at tcnt=15, rxs=1 loads rx_data from the shift register and pulses rx_valid; rxs=0 pulses frame_err and leaves rx_data unchanged; both cases go to IDLE.
REQ-018 After a framing error, a new frame shall start only after a falling edge, so a held-low break line produces no further frames.
REQ-019 rx_valid and frame_err shall never be high together; each lasts exactly one sysclk cycle.
REQ-020 Latency: rx_valid shall assert at 8 + 9x16 = 152 sample ticks after the start-bit falling edge is seen (± 1 tick), plus one sysclk.
REQ-021 tcnt shall wrap modulo 16 with no overflow state; bcnt shall not exceed DATA_BITS-1.
REQ-022 A frame may begin on the tick immediately after the STOP-to-IDLE transition (back-to-back frames).

Reset
REQ-023 On reset_n=0, the block shall go to IDLE with tcnt=0, bcnt=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0, rx_busy=0, and both synchronizer flops and the previous-sample flop set to 1.
REQ-024 Reset asserted mid-frame shall discard the partial byte with no pulse on either output.

Structure
REQ-025 Package uart_pkg shall hold the state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3), OVERSAMPLE, and DATA_BITS.
REQ-026 Sub-module uart_rx_sync shall implement the 2-flop synchronizer with reset value 1.
REQ-027 The target RTL size is about 150 lines: one FSM process with registered outputs, plus the synchronizer.

Verification
REQ-028 Send 0xA5 at 16 ticks/bit -> exactly one rx_valid pulse, rx_data=0xA5, frame_err=0, rx_busy low afterwards.
REQ-029 Drive a 4-tick low glitch on an idle line -> return to IDLE, no rx_valid or frame_err pulse, rx_data unchanged.
REQ-030 Send 0x3C with the stop bit low -> frame_err pulses once, rx_valid=0, rx_data keeps its previous value; hold the line low for 40 bit times -> no further pulses.
REQ-031 Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses, data 0x00 then 0xFF.
REQ-032 Assert reset_n low during bit 4 of 0x5A, release it, then send 0x81 -> no pulse for the aborted frame, one rx_valid with 0x81.
REQ-033 Send 0x55 with sample_tick at 16 ticks/bit and the line skewed ±2 ticks per frame -> rx_data=0x55 in each case.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receiver.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start-bit detection, mid-bit sampling, LSB first,
// one-cycle rx_valid / frame_err pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 sysclk,
  input  logic                 reset_n,
  input  logic                 sample_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS);
  localparam logic [TCNT_W-1:0] TICK_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(DATA_BITS - 1);

  logic                 rxs;
  logic                 fall_edge;
  rx_state_e            state_q;
  logic [TCNT_W-1:0]    tcnt_q;
  logic [BCNT_W-1:0]    bcnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 prev_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;

  uart_rx_sync u_sync (
    .clk_i  (sysclk),
    .rst_ni (reset_n),
    .async_i(rxd),
    .sync_o (rxs)
  );

  assign shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
  // prev_q is the line level at the previous tick, so a break held low never re-triggers
  assign fall_edge = prev_q & ~rxs;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      prev_q      <= 1'b1;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (sample_tick) begin
        prev_q <= rxs;
        tcnt_q <= tcnt_q + 1'b1;
        case (state_q)
          IDLE: begin
            tcnt_q <= '0;
            if (fall_edge) begin
              state_q <= START;
            end
          end
          START: begin
            if (tcnt_q == TICK_MID) begin
              tcnt_q  <= '0;
              bcnt_q  <= '0;
              state_q <= rxs ? IDLE : DATA;
            end
          end
          DATA: begin
            if (tcnt_q == TICK_LAST) begin
              tcnt_q  <= '0;
              shift_q <= shift_d;
              bcnt_q  <= bcnt_q + 1'b1;
              if (bcnt_q == BIT_LAST) begin
                bcnt_q  <= '0;
                state_q <= STOP;
              end
            end
          end
          STOP: begin
            if (tcnt_q == TICK_LAST) begin
              tcnt_q  <= '0;
              state_q <= IDLE;
              if (rxs) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven tick-accurately and the expected
// bytes go through a scoreboard queue that the output monitor drains.
module tb_uart_rx;

  localparam int TICK_DIV  = 4;
  localparam int BIT_TICKS = 16;

  logic       sysclk = 1'b0;
  logic       reset_n;
  logic       sample_tick;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int checkCount  = 0;
  int passCount   = 0;
  int failCount   = 0;
  int validPulses = 0;
  int errPulses   = 0;
  int bothHigh    = 0;
  int validRun    = 0;
  int errRun      = 0;
  int maxValidRun = 0;
  int maxErrRun   = 0;
  int tickCount   = 0;
  int startTick   = 0;
  int lastLatency = 0;

  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];

  uart_rx dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .sample_tick(sample_tick),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 sysclk = ~sysclk;

  // Baud generator stand-in: one-cycle tick every TICK_DIV sysclks
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge sysclk);
      sample_tick = 1'b1;
      @(negedge sysclk);
      sample_tick = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge sysclk);
      if (sample_tick) tickCount++;
    end
  end

  // Output monitor: captures bytes, pulse counts and pulse widths
  initial begin
    forever begin
      @(negedge sysclk);
      if (rx_valid) begin
        if (validRun == 0) begin
          validPulses++;
          gotQ.push_back(rx_data);
          lastLatency = tickCount - startTick;
        end
        validRun++;
        if (validRun > maxValidRun) maxValidRun = validRun;
      end else begin
        validRun = 0;
      end
      if (frame_err) begin
        if (errRun == 0) errPulses++;
        errRun++;
        if (errRun > maxErrRun) maxErrRun = errRun;
      end else begin
        errRun = 0;
      end
      if (rx_valid && frame_err) bothHigh++;
    end
  end

  task automatic waitTicks(input int n);
    repeat (n * TICK_DIV) @(negedge sysclk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one full frame; skew lengthens/shortens two bits by skew/2 ticks each
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int skew);
    int bitTicks;
    if (stopBit) expQ.push_back(data);
    for (int i = 0; i < 10; i++) begin
      bitTicks = BIT_TICKS;
      if (i == 3 || i == 7) bitTicks = BIT_TICKS + skew / 2;
      if (i == 0) begin
        rxd       = 1'b0;
        startTick = tickCount;
      end else if (i < 9) begin
        rxd = data[i-1];
      end else begin
        rxd = stopBit;
      end
      waitTicks(bitTicks);
    end
  endtask

  task automatic checkScoreboard(input string tag);
    logic [7:0] e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({tag, "_received"}, 32'(gotQ.size() > 0), 32'd1);
      if (gotQ.size() > 0) checkOutput({tag, "_data"}, 32'(gotQ.pop_front()), 32'(e));
    end
    checkOutput({tag, "_extra"}, 32'(gotQ.size()), 32'd0);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (rx_busy === 1'b1 && n < 200 * TICK_DIV) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin
    int skews[3];
    int v0;
    int e0;
    logic [7:0] abortByte;
    skews     = '{-2, 0, 2};
    abortByte = 8'h5A;

    rxd     = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge sysclk);
    checkOutput("reset_rx_data", 32'(rx_data), 32'h0);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    checkOutput("reset_rx_busy", 32'(rx_busy), 32'h0);
    reset_n = 1'b1;
    waitTicks(8);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1, 0);
    waitTicks(4);
    checkScoreboard("a5");
    checkOutput("a5_latency", 32'(lastLatency >= 152 && lastLatency <= 154), 32'd1);
    checkOutput("a5_frame_err", 32'(errPulses), 32'd0);
    checkOutput("a5_pulses", 32'(validPulses), 32'd1);
    waitIdle("a5");

    $display("[TB] 4-tick glitch on idle line");
    v0  = validPulses;
    rxd = 1'b0;
    waitTicks(4);
    rxd = 1'b1;
    waitTicks(24);
    checkOutput("glitch_busy", 32'(rx_busy), 32'd0);
    checkOutput("glitch_valid", 32'(validPulses - v0), 32'd0);
    checkOutput("glitch_err", 32'(errPulses), 32'd0);
    checkOutput("glitch_data", 32'(rx_data), 32'hA5);

    $display("[TB] 0x3C with low stop bit, then break");
    v0 = validPulses;
    applyStimulus(8'h3C, 1'b0, 0);
    waitTicks(4);
    checkOutput("ferr_pulse", 32'(errPulses), 32'd1);
    checkOutput("ferr_valid", 32'(validPulses - v0), 32'd0);
    checkOutput("ferr_data", 32'(rx_data), 32'hA5);
    waitTicks(40 * BIT_TICKS);
    checkOutput("break_err", 32'(errPulses), 32'd1);
    checkOutput("break_valid", 32'(validPulses - v0), 32'd0);
    checkOutput("break_busy", 32'(rx_busy), 32'd0);
    rxd = 1'b1;
    waitTicks(32);
    checkScoreboard("break");

    $display("[TB] back-to-back 0x00, 0xFF");
    applyStimulus(8'h00, 1'b1, 0);
    applyStimulus(8'hFF, 1'b1, 0);
    waitTicks(8);
    checkScoreboard("b2b");

    $display("[TB] reset during bit 4 of 0x5A, then 0x81");
    v0  = validPulses;
    e0  = errPulses;
    rxd = 1'b0;
    waitTicks(BIT_TICKS);
    for (int i = 0; i < 4; i++) begin
      rxd = abortByte[i];
      waitTicks(BIT_TICKS);
    end
    rxd = abortByte[4];
    waitTicks(BIT_TICKS / 2);
    checkOutput("abort_busy_mid", 32'(rx_busy), 32'd1);
    reset_n = 1'b0;
    repeat (3) @(negedge sysclk);
    checkOutput("abort_rx_data", 32'(rx_data), 32'h0);
    checkOutput("abort_busy", 32'(rx_busy), 32'd0);
    reset_n = 1'b1;
    rxd     = 1'b1;
    waitTicks(32);
    checkOutput("abort_valid", 32'(validPulses - v0), 32'd0);
    checkOutput("abort_err", 32'(errPulses - e0), 32'd0);
    applyStimulus(8'h81, 1'b1, 0);
    waitTicks(4);
    checkScoreboard("rst81");

    $display("[TB] 0x55 with line skew");
    foreach (skews[k]) begin
      applyStimulus(8'h55, 1'b1, skews[k]);
      waitTicks(8);
      checkScoreboard($sformatf("skew%0d", skews[k]));
    end
    waitIdle("end");

    checkOutput("valid_width", 32'(maxValidRun), 32'd1);
    checkOutput("err_width", 32'(maxErrRun), 32'd1);
    checkOutput("valid_and_err", 32'(bothHigh), 32'd0);
    checkOutput("valid_total", 32'(validPulses), 32'd7);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
